// File: rtl/fm_ctrl_pkg.sv
// Shared types, widths and the clamped frequency-step helper for the FM sweep controller.
// Optional triangle sweeping in fm_sweep_ctrl is enabled with FM_SWEEP_TRIANGLE_EN.
package fm_ctrl_pkg;

   localparam int FM_FW  = 24;
   localparam int FM_DW  = 32;
   localparam int FM_FDW = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DWELL = 2'd1,
      DONE  = 2'd2
   } state_t;

   // One extra bit catches the carry or borrow, so the result clamps to stop and never wraps.
   function automatic logic [FM_FW-1:0] next_freq(
      input logic [FM_FW-1:0] cur,
      input logic [FM_FW-1:0] step,
      input logic [FM_FW-1:0] stop,
      input logic             up
   );
      logic [FM_FW:0]   w_sum;
      logic [FM_FW-1:0] w_res;
      if (up) begin
         w_sum = {1'b0, cur} + {1'b0, step};
         w_res = (w_sum >= {1'b0, stop}) ? stop : w_sum[FM_FW-1:0];
      end else begin
         w_sum = {1'b0, cur} - {1'b0, step};
         w_res = (w_sum[FM_FW] || (w_sum[FM_FW-1:0] <= stop)) ? stop : w_sum[FM_FW-1:0];
      end
      return w_res;
   endfunction

endpackage

// File: rtl/fm_dwell_timer.sv
// Dwell counter for one sweep point: counts while enabled and pulses o_expire on the
// last cycle of the point (counter == eff_dwell-1), clearing itself at the same edge.
module fm_dwell_timer
   import fm_ctrl_pkg::*;
#(
   parameter int DW = FM_DW
) (
   input  logic          clk_100M,
   input  logic          rst_n,
   input  logic          i_clr,
   input  logic          i_en,
   input  logic [DW-1:0] i_eff_dwell,
   output logic          o_expire
);

   logic [DW-1:0] r_cnt;

   assign o_expire = i_en && (r_cnt == (i_eff_dwell - DW'(1)));

   // NOTE: sequential state is written only with non-blocking assignments so every
   // register samples the pre-edge values, regardless of block ordering.
   always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr || o_expire) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + DW'(1);
      end
   end

endmodule

// File: rtl/fm_sweep_ctrl.sv
// Linear carrier-frequency sweep sequencer feeding fc/fd to the FM datapath.
// Define FM_SWEEP_TRIANGLE_EN to add the tri_mode input (up/down triangle sweeping).
module fm_sweep_ctrl
   import fm_ctrl_pkg::*;
#(
   parameter int FW  = FM_FW,
   parameter int DW  = FM_DW,
   parameter int FDW = FM_FDW
) (
   input  logic           clk_100M,
   input  logic           rst_n,
   input  logic           start,
   input  logic           abort,
   input  logic           cont,
   input  logic [FW-1:0]  f_start,
   input  logic [FW-1:0]  f_stop,
   input  logic [FW-1:0]  f_step,
   input  logic [DW-1:0]  dwell,
   input  logic [FDW-1:0] fd_in,
`ifdef FM_SWEEP_TRIANGLE_EN
   input  logic           tri_mode,
`endif
   output logic [FW-1:0]  fc,
   output logic [FDW-1:0] fd,
   output logic           busy,
   output logic           done,
   output logic           step_tick
);

   state_t         r_state;
   logic [FW-1:0]  r_fc;
   logic [FDW-1:0] r_fd;
   logic           r_busy;
   logic           r_done;
   logic           r_step_tick;

   // Sweep configuration captured at accept; live inputs are ignored mid-sweep.
   logic [FW-1:0]  r_f_start;
   logic [FW-1:0]  r_f_stop;
   logic [FW-1:0]  r_step;
   logic [DW-1:0]  r_dwell;
   logic           r_cont;
   logic           r_tri;
   logic           r_up;
   logic           r_to_stop;

   logic           w_tri_mode;
   logic           w_accept;
   logic           w_expire;
   logic           w_dir_up;
   logic [FW-1:0]  w_target;

`ifdef FM_SWEEP_TRIANGLE_EN
   assign w_tri_mode = tri_mode;
`else
   assign w_tri_mode = 1'b0;
`endif

   assign w_accept = start && !abort && ((r_state == IDLE) || (r_state == DONE));
   assign w_target = r_to_stop ? r_f_stop : r_f_start;
   assign w_dir_up = r_to_stop ? r_up : !r_up;

   fm_dwell_timer #(
      .DW (DW)
   ) u_dwell_timer (
      .clk_100M    (clk_100M),
      .rst_n       (rst_n),
      .i_clr       (w_accept || abort),
      .i_en        (r_state == DWELL),
      .i_eff_dwell (r_dwell),
      .o_expire    (w_expire)
   );

   always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_fc        <= '0;
         r_fd        <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_step_tick <= 1'b0;
         r_f_start   <= '0;
         r_f_stop    <= '0;
         r_step      <= '0;
         r_dwell     <= '0;
         r_cont      <= 1'b0;
         r_tri       <= 1'b0;
         r_up        <= 1'b0;
         r_to_stop   <= 1'b0;
      end else begin
         r_step_tick <= 1'b0;
         if (abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
         end else if (w_accept) begin
            r_state     <= DWELL;
            r_f_start   <= f_start;
            r_f_stop    <= f_stop;
            r_step      <= (f_step == '0) ? FW'(1) : f_step;
            r_dwell     <= (dwell == '0) ? DW'(1) : dwell;
            r_cont      <= cont;
            r_tri       <= w_tri_mode;
            r_up        <= (f_stop >= f_start);
            r_to_stop   <= 1'b1;
            r_fc        <= f_start;
            r_fd        <= fd_in;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_step_tick <= 1'b1;
         end else if ((r_state == DWELL) && w_expire) begin
            if (r_fc != w_target) begin
               r_fc        <= next_freq(r_fc, r_step, w_target, w_dir_up);
               r_step_tick <= 1'b1;
            end else if (r_tri && r_to_stop) begin
               // Reversal at f_stop: the endpoint was already held, head straight back.
               r_to_stop   <= 1'b0;
               r_fc        <= next_freq(r_fc, r_step, r_f_start, !r_up);
               r_step_tick <= 1'b1;
            end else if (r_tri && r_cont) begin
               r_to_stop   <= 1'b1;
               r_fc        <= next_freq(r_fc, r_step, r_f_stop, r_up);
               r_step_tick <= 1'b1;
            end else if (!r_tri && r_cont) begin
               r_fc        <= r_f_start;
               r_step_tick <= 1'b1;
            end else begin
               r_state <= DONE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
         end
      end
   end

   assign fc        = r_fc;
   assign fd        = r_fd;
   assign busy      = r_busy;
   assign done      = r_done;
   assign step_tick = r_step_tick;

endmodule
